uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Sequencing controller for the UART transmit path. It accepts a byte-valid strobe, then steps the frame through four phases: start bit, DATA_WIDTH data bits, optional parity bit, stop bit. For each phase it drives the 2-bit output-mux select, the serializer load/shift enables and the busy flag. One state per bit period (one CLK = one bit time, baud tick handled upstream via clock enable).

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9)
CNT_W, 4, width of internal data-bit counter (must hold DATA_WIDTH-1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
Data_Valid  in  1  single-cycle request: a new byte is on the parallel bus
PAR_EN  in  1  parity enable; sampled only when a frame is accepted
ser_load  out  1  one-cycle pulse: serializer captures parallel data
ser_en  out  1  serializer shift enable (one shift per data-bit cycle)
Mux_sel  out  2  output mux select: 00 start, 01 data, 10 parity, 11 stop/idle
busy  out  1  frame in progress; upstream must not present new data unless accept is allowed (see below)

Behaviour:
- All logic clocked on CLK rising edge. RST is synchronous and active-high.
- Reset values: state IDLE, counter 0, ser_load 0, ser_en 0, Mux_sel 2'b11, busy 0, latched parity-enable 0.
- Outputs are Moore, decoded from registered state and counter. The external mux adds its own 1-cycle register; the controller does not compensate.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Mux_sel=11, busy=0.
  - Data_Valid=1 -> START; latch PAR_EN.
- START (1 cycle):
  - Mux_sel=00, busy=1, ser_load=1.
  - Next state DATA, counter cleared to 0.
- DATA (DATA_WIDTH cycles):
  - Mux_sel=01, busy=1, ser_en=1.
  - Counter increments each cycle.
  - When counter==DATA_WIDTH-1: go to PARITY if latched parity-enable=1, else STOP.
- PARITY (1 cycle):
  - Mux_sel=10, busy=1.
  - Next state STOP.
- STOP (1 cycle):
  - Mux_sel=11, busy=1.
  - Data_Valid=1 in this cycle -> START (back-to-back frame, no idle gap); re-latch PAR_EN.
  - Otherwise -> IDLE.
- Accept rule: Data_Valid is honoured only in IDLE or STOP. It is ignored (no queuing, no side effect) in START/DATA/PARITY.
- Latency: Data_Valid at cycle t -> START at t+1.
- Frame length: 2+DATA_WIDTH cycles without parity, 3+DATA_WIDTH with parity.
- A PAR_EN change mid-frame has no effect on the current frame.
- RST asserted in any state -> next edge returns to reset values. A frame in progress is aborted; the line shows Mux_sel=11.
- ser_load and ser_en are never high in the same cycle. busy is low only in IDLE.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - mux-select constants SEL_START=2'b00, SEL_DATA=2'b01, SEL_PAR=2'b10, SEL_STOP=2'b11.
- The same constants are to be used by the TX mux and the serializer.
- No sub-module required. The bit counter stays inline; it is too small to justify a separate module.

Test Plan:
- Reset: hold RST=1 for 3 cycles with Data_Valid=1 -> Mux_sel=11, busy=0, ser_load=0, ser_en=0 throughout; IDLE after release.
- 8-bit frame, no parity: Data_Valid pulse at t, PAR_EN=0 -> Mux_sel 00 at t+1, 01 for t+2..t+9, 11 at t+10; ser_load only at t+1; ser_en for exactly 8 cycles; busy high t+1..t+10; IDLE at t+11.
- Parity frame: PAR_EN=1 at accept, driven to 0 at t+3 -> Mux_sel=10 at t+10, stop at t+11, busy drops at t+12.
- Back-to-back: Data_Valid again during STOP -> START the next cycle with no IDLE cycle; total of two frames = 20 cycles (no parity).
- Ignored request: Data_Valid pulses during DATA -> no extra ser_load, frame timing unchanged, IDLE after stop.
- Mid-frame reset: RST=1 at 4th data bit -> next cycle Mux_sel=11, busy=0, ser_en=0. A fresh Data_Valid after release gives a normal full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   state_e      : transmit controller frame phases
//   SEL_*        : output-mux select codes, shared by the TX controller,
//                  the TX output mux and the serializer
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;  // also the idle line level

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Sequencing controller for the UART transmit path. One clock is one bit
// period (baud enable is applied upstream). A frame is:
//   start bit, DATA_WIDTH data bits, optional parity bit, stop bit.
// Outputs are Moore, decoded from the registered state and bit counter.
//
// Parameters
//   DATA_WIDTH : data bits per frame (5..9)
//   CNT_W      : width of the data-bit counter (must hold DATA_WIDTH-1)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous, active-high reset
//   Data_Valid in   one-cycle request; honoured only in IDLE or STOP
//   PAR_EN     in   parity enable, latched when a frame is accepted
//   ser_load   out  serializer parallel load pulse (START)
//   ser_en     out  serializer shift enable (each DATA cycle)
//   Mux_sel    out  output mux select (SEL_* codes from uart_pkg)
//   busy       out  frame in progress (low only in IDLE)
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    output logic       ser_load,
    output logic       ser_en,
    output logic [1:0] Mux_sel,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              par_en_q, par_en_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // races between the registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Data_Valid) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                // A request in the stop cycle chains the next frame with no
                // idle gap; parity mode is re-sampled for that frame.
                if (Data_Valid) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Unused encodings fall back to IDLE.
                state_d  = IDLE;
                cnt_d    = '0;
                par_en_d = 1'b0;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        ser_load = 1'b0;
        ser_en   = 1'b0;
        Mux_sel  = SEL_STOP;
        busy     = 1'b0;

        case (state_q)
            IDLE: begin
                Mux_sel = SEL_STOP;
            end
            START: begin
                Mux_sel  = SEL_START;
                busy     = 1'b1;
                ser_load = 1'b1;
            end
            DATA: begin
                Mux_sel = SEL_DATA;
                busy    = 1'b1;
                ser_en  = 1'b1;
            end
            PARITY: begin
                Mux_sel = SEL_PAR;
                busy    = 1'b1;
            end
            STOP: begin
                Mux_sel = SEL_STOP;
                busy    = 1'b1;
            end
            default: begin
                Mux_sel = SEL_STOP;
            end
        endcase
    end

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl (DATA_WIDTH = 8). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       ser_load;
    logic       ser_en;
    logic [1:0] Mux_sel;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_W      (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .ser_load   (ser_load),
        .ser_en     (ser_en),
        .Mux_sel    (Mux_sel),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check all outputs for the current cycle, then advance to just after
    // the next rising edge.
    task automatic cyc(input string tag, input logic [1:0] sel, input logic bsy,
                       input logic ld, input logic en);
        @(negedge CLK);
        check({tag, ".sel"},  32'(Mux_sel),  32'(sel));
        check({tag, ".busy"}, 32'(busy),     32'(bsy));
        check({tag, ".load"}, 32'(ser_load), 32'(ld));
        check({tag, ".en"},   32'(ser_en),   32'(en));
        if (busy === 1'b1) busy_cycles++;
        @(posedge CLK);
        #1;
    endtask

    // START, DW data cycles and optional parity; the caller handles STOP.
    task automatic frame_body(input string tag, input logic par);
        cyc({tag, "_start"}, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DW; i++)
            cyc({tag, "_data"}, 2'b01, 1'b1, 1'b0, 1'b1);
        if (par)
            cyc({tag, "_par"}, 2'b10, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a pending request: stays idle throughout.
        RST = 1'b1;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        repeat (3) cyc("rst", 2'b11, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        Data_Valid = 1'b0;
        cyc("post_rst", 2'b11, 1'b0, 1'b0, 1'b0);

        // Plain 8-bit frame, no parity.
        Data_Valid = 1'b1;
        PAR_EN = 1'b0;
        cyc("a_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        frame_body("a", 1'b0);
        cyc("a_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("a_idle", 2'b11, 1'b0, 1'b0, 1'b0);

        // Parity frame; PAR_EN dropped at t+3 must not matter.
        Data_Valid = 1'b1;
        PAR_EN = 1'b1;
        cyc("p_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        cyc("p_start", 2'b00, 1'b1, 1'b1, 1'b0);
        cyc("p_data", 2'b01, 1'b1, 1'b0, 1'b1);
        PAR_EN = 1'b0;
        for (int i = 1; i < DW; i++)
            cyc("p_data", 2'b01, 1'b1, 1'b0, 1'b1);
        cyc("p_par", 2'b10, 1'b1, 1'b0, 1'b0);
        cyc("p_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("p_idle", 2'b11, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap: 20 busy cycles.
        busy_cycles = 0;
        Data_Valid = 1'b1;
        cyc("b_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        frame_body("b1", 1'b0);
        Data_Valid = 1'b1;
        cyc("b1_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        frame_body("b2", 1'b0);
        cyc("b2_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("b_idle", 2'b11, 1'b0, 1'b0, 1'b0);
        check("b2b_busy_cycles", 32'(busy_cycles), 32'd20);

        // Chained frame re-latches PAR_EN in STOP.
        Data_Valid = 1'b1;
        cyc("r_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        frame_body("r1", 1'b0);
        Data_Valid = 1'b1;
        PAR_EN = 1'b1;
        cyc("r1_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        PAR_EN = 1'b0;
        frame_body("r2", 1'b1);
        cyc("r2_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("r_idle", 2'b11, 1'b0, 1'b0, 1'b0);

        // Requests during DATA are ignored (also PAR_EN toggling).
        Data_Valid = 1'b1;
        cyc("i_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        cyc("i_start", 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DW; i++) begin
            Data_Valid = (i == 2 || i == 4);
            PAR_EN     = (i == 2 || i == 4);
            cyc("i_data", 2'b01, 1'b1, 1'b0, 1'b1);
        end
        Data_Valid = 1'b0;
        PAR_EN = 1'b0;
        cyc("i_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("i_idle", 2'b11, 1'b0, 1'b0, 1'b0);

        // Reset at the 4th data bit aborts the frame.
        Data_Valid = 1'b1;
        cyc("m_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        cyc("m_start", 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("m_data", 2'b01, 1'b1, 1'b0, 1'b1);
        RST = 1'b1;
        cyc("m_data4", 2'b01, 1'b1, 1'b0, 1'b1);
        RST = 1'b0;
        cyc("m_aborted", 2'b11, 1'b0, 1'b0, 1'b0);

        // Fresh frame after the abort is complete and normal.
        Data_Valid = 1'b1;
        cyc("f_accept", 2'b11, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        frame_body("f", 1'b0);
        cyc("f_stop", 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("f_idle", 2'b11, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
